regfile_mp_sb: RTL and testbench

- Parametrised multi-port register file for the pipelined KGP-miniRISC datapath.
- Provides NUM_RD read ports and two write ports: W0 for the ALU writeback and W1 for the load writeback.
- Holds a per-register pending scoreboard so decode can detect RAW hazards.
- Sits between decode/issue and writeback; replaces the single-write, two-read register file.

---
 rtl/regfile_mp_sb.sv | 122 ++++++++++++
 tb/tb_regfile_mp_sb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports and a RAW pending scoreboard.
// Optional write-through bypass on reads when REGFILE_BYPASS_EN is defined.
module regfile_mp_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic                     any_pending
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              any_pending_q;
    logic              any_pending_d;

    logic w0_hit;
    logic w1_hit;

    assign w0_hit = we0 && (waddr0 != '0);
    assign w1_hit = we1 && (waddr1 != '0);

    // Next register contents: W1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (w0_hit) begin
            regs_d[waddr0] = wdata0;
        end
        if (w1_hit) begin
            regs_d[waddr1] = wdata1;
        end
        regs_d[0] = '0;
    end

    // Next scoreboard: flush beats issue, issue beats a same-cycle writeback clear.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (w0_hit) begin
                pend_d[waddr0] = 1'b0;
            end
            if (w1_hit) begin
                pend_d[waddr1] = 1'b0;
            end
            if (iss_valid) begin
                pend_d[iss_addr] = 1'b1;
            end
        end
        pend_d[0]     = 1'b0;
        any_pending_d = |pend_d;
    end

    // State update with asynchronous clear of data and scoreboard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
            end
            pend_q        <= '0;
            any_pending_q <= 1'b0;
        end else begin
            regs_q        <= regs_d;
            pend_q        <= pend_d;
            any_pending_q <= any_pending_d;
        end
    end

    assign any_pending = any_pending_q;

    // Combinational read ports; r0 and reset force zero data and no pending.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              p;
        a          = '0;
        d          = '0;
        p          = 1'b0;
        rd_data    = '0;
        rd_pending = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = rd_addr[k*ADDR_W +: ADDR_W];
            d = regs_q[a];
            p = pend_q[a];
`ifdef REGFILE_BYPASS_EN
            if (w0_hit && (waddr0 == a)) begin
                d = wdata0;
                p = 1'b0;
            end
            if (w1_hit && (waddr1 == a)) begin
                d = wdata1;
                p = 1'b0;
            end
`endif
            if (rst || (a == '0)) begin
                d = '0;
                p = 1'b0;
            end
            rd_data[k*DATA_W +: DATA_W] = d;
            rd_pending[k]               = p;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb with a read-expectation scoreboard.
// Expectations are queued as stimulus is applied and drained at the negedge.
module tb_regfile_mp_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk;
    logic             rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_pending;
    logic             we0;
    logic [AW-1:0]    waddr0;
    logic [DW-1:0]    wdata0;
    logic             we1;
    logic [AW-1:0]    waddr1;
    logic [DW-1:0]    wdata1;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic             flush;
    logic             any_pending;

    int checks = 0;
    int errors = 0;
    int step   = 0;

    typedef struct {
        int          tag;
        int          port;
        logic [31:0] data;
        logic        pend;
    } exp_t;

    exp_t sb[$];

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .we0        (we0),
        .waddr0     (waddr0),
        .wdata0     (wdata0),
        .we1        (we1),
        .waddr1     (waddr1),
        .wdata1     (wdata1),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .flush      (flush),
        .any_pending(any_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        we0 = 0; waddr0 = '0; wdata0 = '0;
        we1 = 0; waddr1 = '0; wdata1 = '0;
        iss_valid = 0; iss_addr = '0; flush = 0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr[0*AW +: AW] = AW'(a0);
        rd_addr[1*AW +: AW] = AW'(a1);
    endtask

    task automatic expect_rd(input int port, input logic [31:0] d, input logic p);
        exp_t e;
        e.tag  = step;
        e.port = port;
        e.data = d;
        e.pend = p;
        sb.push_back(e);
    endtask

    // Wait past the next rising edge so the previous inputs have committed.
    task automatic tick();
        @(posedge clk);
        #1;
        step++;
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] got_d;
        logic        got_p;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            got_d = rd_data[e.port*DW +: DW];
            got_p = rd_pending[e.port];
            checks++;
            assert (got_d === e.data) else begin
                errors++;
                $error("FAIL rd_data step%0d port%0d got %h exp %h",
                       e.tag, e.port, got_d, e.data);
            end
            checks++;
            assert (got_p === e.pend) else begin
                errors++;
                $error("FAIL rd_pending step%0d port%0d got %b exp %b",
                       e.tag, e.port, got_p, e.pend);
            end
        end
    endtask

    task automatic check_any(input logic exp);
        checks++;
        assert (any_pending === exp) else begin
            errors++;
            $error("FAIL any_pending step%0d got %b exp %b",
                   step, any_pending, exp);
        end
    endtask

    initial begin
        idle();
        rd_addr = '0;
        rst = 1;

        // Reset with reads pending on r0 and r5.
        set_rd(0, 5);
        expect_rd(0, 32'h0, 1'b0);
        expect_rd(1, 32'h0, 1'b0);
        drain();
        check_any(1'b0);
        #1 rst = 0;

        // Dual write to distinct registers.
        tick();
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'h1111_1111;
        we1 = 1; waddr1 = 5'd4; wdata1 = 32'h2222_2222;
        tick();
        idle();
        set_rd(3, 4);
        expect_rd(0, 32'h1111_1111, 1'b0);
        expect_rd(1, 32'h2222_2222, 1'b0);
        drain();

        // Same-address collision: W1 wins.
        tick();
        we0 = 1; waddr0 = 5'd7; wdata0 = 32'hAAAA_0000;
        we1 = 1; waddr1 = 5'd7; wdata1 = 32'h0000_BBBB;
        tick();
        idle();
        we0 = 1; waddr0 = 5'd0; wdata0 = 32'hDEAD_BEEF;
        iss_valid = 1; iss_addr = 5'd0;
        tick();
        idle();
        set_rd(7, 0);
        expect_rd(0, 32'h0000_BBBB, 1'b0);
        expect_rd(1, 32'h0, 1'b0);
        drain();
        check_any(1'b0);

        // Issue sets pending, writeback clears it.
        tick();
        iss_valid = 1; iss_addr = 5'd9;
        tick();
        idle();
        set_rd(9, 3);
        expect_rd(0, 32'h0, 1'b1);
        expect_rd(1, 32'h1111_1111, 1'b0);
        drain();
        check_any(1'b1);
        tick();
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'h5;
        tick();
        idle();
        expect_rd(0, 32'h5, 1'b0);
        drain();
        check_any(1'b0);

        // Issue beats same-cycle writeback clear; data still written.
        tick();
        iss_valid = 1; iss_addr = 5'd9;
        we1 = 1; waddr1 = 5'd9; wdata1 = 32'h6;
        tick();
        idle();
        set_rd(9, 2);
        expect_rd(0, 32'h6, 1'b1);
        expect_rd(1, 32'h0, 1'b0);
        drain();
        check_any(1'b1);

        // Flush wins over a same-cycle issue.
        tick();
        flush = 1; iss_valid = 1; iss_addr = 5'd2;
        tick();
        idle();
        expect_rd(0, 32'h6, 1'b0);
        expect_rd(1, 32'h0, 1'b0);
        drain();
        check_any(1'b0);

        // Same-cycle write versus read on r12.
        tick();
        set_rd(12, 4);
        we0 = 1; waddr0 = 5'd12; wdata0 = 32'hCAFE_0001;
`ifdef REGFILE_BYPASS_EN
        expect_rd(0, 32'hCAFE_0001, 1'b0);
`else
        expect_rd(0, 32'h0, 1'b0);
`endif
        expect_rd(1, 32'h2222_2222, 1'b0);
        drain();
        tick();
        idle();
        expect_rd(0, 32'hCAFE_0001, 1'b0);
        drain();

        // Same-cycle writeback of a pending register, both ports colliding.
        tick();
        iss_valid = 1; iss_addr = 5'd13;
        tick();
        idle();
        set_rd(4, 13);
        we0 = 1; waddr0 = 5'd13; wdata0 = 32'h0000_0055;
        we1 = 1; waddr1 = 5'd13; wdata1 = 32'h0000_0077;
`ifdef REGFILE_BYPASS_EN
        expect_rd(1, 32'h0000_0077, 1'b0);
`else
        expect_rd(1, 32'h0, 1'b1);
`endif
        expect_rd(0, 32'h2222_2222, 1'b0);
        drain();
        check_any(1'b1);
        tick();
        idle();
        expect_rd(1, 32'h0000_0077, 1'b0);
        drain();
        check_any(1'b0);

        // Asynchronous reset mid-operation clears data and scoreboard.
        tick();
        iss_valid = 1; iss_addr = 5'd20;
        tick();
        idle();
        set_rd(3, 20);
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'h1234_5678;
        #2 rst = 1;
        #1;
        checks++;
        assert (rd_data === '0) else begin
            errors++;
            $error("FAIL rst_async_data got %h exp 0", rd_data);
        end
        check_any(1'b0);
        @(posedge clk);
        #1 rst = 0;
        idle();
        step++;
        expect_rd(0, 32'h0, 1'b0);
        expect_rd(1, 32'h0, 1'b0);
        drain();
        check_any(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
